// File: rtl/adder_share_ctrl.sv
// adder_share_ctrl
// Shares one external ripple-carry adder between two requesters. Requests
// are granted round-robin. Operands and carry-in are registered into the
// adder and held for a fixed settle time. The sum is then captured together
// with the N/Z/C/V flags. The controller keeps one carry flag per requester
// so that ADC and SBC chain independently for each requester.

module adder_share_ctrl #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_cout
);

  localparam int MSB = WIDTH - 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_ADC = 2'd1;
  localparam logic [1:0] OP_SUB = 2'd2;
  localparam logic [1:0] OP_SBC = 2'd3;

  // Counter value at which the adder output has been stable long enough
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  // Registered state
  logic [1:0]       state_q,      state_d;
  logic [3:0]       cnt_q,        cnt_d;
  logic             last_q,       last_d;
  logic             id_q,         id_d;
  logic [1:0]       cflag_q,      cflag_d;
  logic [WIDTH-1:0] add_a_q,      add_a_d;
  logic [WIDTH-1:0] add_b_q,      add_b_d;
  logic             add_cin_q,    add_cin_d;
  logic             rsp_valid_q,  rsp_valid_d;
  logic             rsp_id_q,     rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic [3:0]       rsp_flags_q,  rsp_flags_d;

  // Requester ports gathered into arrays indexed by requester id
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_op [2];
  logic [WIDTH-1:0] req_a  [2];
  logic [WIDTH-1:0] req_b  [2];

  assign req_valid = {req1_valid, req0_valid};
  assign req_op[0] = req0_op;
  assign req_op[1] = req1_op;
  assign req_a[0]  = req0_a;
  assign req_a[1]  = req1_a;
  assign req_b[0]  = req0_b;
  assign req_b[1]  = req1_b;

  // Arbitration and operand selection
  logic             grant_id;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] sel_b_eff;
  logic             sel_cin;

  // Capture-time flag terms
  logic cap_n;
  logic cap_z;
  logic cap_c;
  logic cap_v;

  // Round-robin: on contention the requester that did not win last time gets the grant
  always_comb begin
    grant_id = 1'b0;
    if (req_valid[0] && req_valid[1]) begin
      grant_id = ~last_q;
    end else if (req_valid[1]) begin
      grant_id = 1'b1;
    end
  end

  // Ready is offered only in IDLE, and only to the granted requester
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign req_ready[gi] = (state_q == ST_IDLE) && req_valid[gi] && (grant_id == 1'(gi));
    end
  endgenerate

  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];

  // Operand B is inverted for subtraction. Carry-in selects add, add-with-carry or the borrow form
  always_comb begin
    sel_op    = req_op[grant_id];
    sel_a     = req_a[grant_id];
    sel_b     = req_b[grant_id];
    sel_b_eff = sel_op[1] ? ~sel_b : sel_b;
    sel_cin   = 1'b0;
    case (sel_op)
      OP_ADD:  sel_cin = 1'b0;
      OP_ADC:  sel_cin = cflag_q[grant_id];
      OP_SUB:  sel_cin = 1'b1;
      OP_SBC:  sel_cin = cflag_q[grant_id];
      default: sel_cin = 1'b0;
    endcase
  end

  // Flags derived from the settled adder output. V compares the operand signs as presented to the adder
  always_comb begin
    cap_n = add_s[MSB];
    cap_z = (add_s == '0);
    cap_c = add_cout;
    cap_v = (add_a_q[MSB] == add_b_q[MSB]) && (add_s[MSB] != add_a_q[MSB]);
  end

  // Sequencing: accept in IDLE, hold operands through SETTLE, present the result in RESP
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    id_d         = id_q;
    cflag_d      = cflag_q;
    add_a_d      = add_a_q;
    add_b_d      = add_b_q;
    add_cin_d    = add_cin_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;

    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          add_a_d   = sel_a;
          add_b_d   = sel_b_eff;
          add_cin_d = sel_cin;
          id_d      = grant_id;
          last_d    = grant_id;
          cnt_d     = 4'd0;
          state_d   = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SETTLE_LAST) begin
          rsp_result_d     = add_s;
          rsp_flags_d      = {cap_n, cap_z, cap_c, cap_v};
          cflag_d[id_q]    = cap_c;
          rsp_id_d         = id_q;
          rsp_valid_d      = 1'b1;
          state_d          = ST_RESP;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers. Reset drops any operation in flight and restarts arbitration with requester 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      last_q       <= 1'b1;
      id_q         <= 1'b0;
      cflag_q      <= 2'b00;
      add_a_q      <= '0;
      add_b_q      <= '0;
      add_cin_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= 4'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      id_q         <= id_d;
      cflag_q      <= cflag_d;
      add_a_q      <= add_a_d;
      add_b_q      <= add_b_d;
      add_cin_q    <= add_cin_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign add_cin    = add_cin_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;

endmodule
